axis_serializer: RTL and testbench



---
 rtl/axis_serializer.sv | 89 ++++++++
 tb/tb_axis_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/axis_serializer.sv
// Wide-to-narrow AXI-Stream serializer: each wide word leaves as DATA_NB narrow
// beats, least significant sub-word first, through a fully registered output.
module axis_serializer #(
    parameter int DATA_NB    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          up_ready,
    input  logic                          up_valid,
    input  logic [DATA_WIDTH*DATA_NB-1:0] up_data,
    input  logic                          up_last,
    input  logic                          down_ready,
    output logic                          down_valid,
    output logic [DATA_WIDTH-1:0]         down_data,
    output logic                          down_last
);

    localparam int WW    = DATA_WIDTH * DATA_NB;
    localparam int CNT_W = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(DATA_NB - 1);

    logic [WW-1:0]    r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_valid;
    logic             r_down_last;

    logic [WW-1:0]    w_sreg_shift;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_final;
    logic             w_up_hs;
    logic             w_down_hs;

    // Sub-word k+1 moves into slot k; the vacated top slot is filled with zeros.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_NB - 1; gi++) begin : g_shift
            assign w_sreg_shift[gi*DATA_WIDTH +: DATA_WIDTH] = r_sreg[(gi+1)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate
    assign w_sreg_shift[WW-1 -: DATA_WIDTH] = '0;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_final   = (r_cnt == CNT_FINAL);
    assign up_ready  = ~r_valid | (down_ready & w_final);
    assign w_up_hs   = up_valid & up_ready;
    assign w_down_hs = r_valid & down_ready;

    assign down_valid = r_valid;
    assign down_data  = r_sreg[DATA_WIDTH-1:0];
    assign down_last  = r_down_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_down_last <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
        end else if (w_up_hs) begin
            // A new word always wins over retiring the final beat, so no bubble.
            r_valid     <= 1'b1;
            r_cnt       <= '0;
            r_last      <= up_last;
            r_down_last <= up_last & (DATA_NB == 1);
        end else if (w_down_hs) begin
            if (w_final) begin
                r_valid     <= 1'b0;
                r_down_last <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_cnt       <= w_cnt_inc;
                r_down_last <= r_last & (w_cnt_inc == CNT_FINAL);
            end
        end
    end

    // The data path carries no reset; its content is meaningless while down_valid is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_up_hs) begin
                r_sreg <= up_data;
            end else if (w_down_hs && !w_final) begin
                r_sreg <= w_sreg_shift;
            end
        end
    end

endmodule

// File: tb/tb_axis_serializer.sv
// Serializer bench: three instances (1, 2 and 4 sub-words of 8 bits) checked every
// cycle against a queue of expected narrow beats built from each accepted wide word.
module tb_axis_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [2:0]  up_valid_v   = '0;
    logic [31:0] up_data_v [3];
    logic [2:0]  up_last_v    = '0;
    logic [2:0]  down_ready_v = 3'b111;
    logic [2:0]  up_ready_v;
    logic [2:0]  down_valid_v;
    logic [7:0]  down_data_v [3];
    logic [2:0]  down_last_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inst
            localparam int NB = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

            axis_serializer #(.DATA_NB(NB), .DATA_WIDTH(8)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .up_ready   (up_ready_v[gi]),
                .up_valid   (up_valid_v[gi]),
                .up_data    (up_data_v[gi][8*NB-1:0]),
                .up_last    (up_last_v[gi]),
                .down_ready (down_ready_v[gi]),
                .down_valid (down_valid_v[gi]),
                .down_data  (down_data_v[gi]),
                .down_last  (down_last_v[gi])
            );

            // Each entry is {last, byte}; a wide word contributes NB entries, LSB first.
            logic [8:0] exp_q [$];

            always @(negedge clk) begin
                logic exp_valid;
                logic exp_up_ready;
                if (rst) begin
                    exp_q.delete();
                end else begin
                    exp_valid    = (exp_q.size() != 0);
                    exp_up_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && down_ready_v[gi]);
                    check($sformatf("nb%0d_down_valid", NB), 32'(down_valid_v[gi]), 32'(exp_valid));
                    check($sformatf("nb%0d_up_ready", NB), 32'(up_ready_v[gi]), 32'(exp_up_ready));
                    if (exp_valid) begin
                        check($sformatf("nb%0d_down_data", NB), 32'(down_data_v[gi]), 32'(exp_q[0][7:0]));
                        check($sformatf("nb%0d_down_last", NB), 32'(down_last_v[gi]), 32'(exp_q[0][8]));
                        if (down_ready_v[gi]) void'(exp_q.pop_front());
                    end
                    if (up_valid_v[gi] && exp_up_ready) begin
                        $display("[TB] nb%0d load data=%h last=%0d", NB, up_data_v[gi][8*NB-1:0], up_last_v[gi]);
                        for (int k = 0; k < NB; k++)
                            exp_q.push_back({up_last_v[gi] && (k == NB - 1), up_data_v[gi][k*8 +: 8]});
                    end
                end
            end
        end
    endgenerate

    task automatic send_word(input int g, input logic [31:0] d, input logic l);
        int n = 0;
        up_valid_v[g] = 1'b1;
        up_data_v[g]  = d;
        up_last_v[g]  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!up_ready_v[g] && n < 50);
        check("send_ready", 32'(up_ready_v[g]), 32'd1);
        @(posedge clk); #1;
        up_valid_v[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
        @(negedge clk);
        check({tag, "_valid"}, 32'(down_valid_v[1]), 32'd1);
        check({tag, "_data"}, 32'(down_data_v[1]), 32'(d));
        check({tag, "_last"}, 32'(down_last_v[1]), 32'(l));
    endtask

    initial begin
        logic [2:0] fired;
        for (int g = 0; g < 3; g++) up_data_v[g] = '0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(down_valid_v[1]), 32'd0);
        check("reset_last", 32'(down_last_v[1]), 32'd0);
        check("reset_up_ready", 32'(up_ready_v[1]), 32'd1);
        idle(1);

        // Single word, free-flowing output.
        send_word(1, 32'hBBAA, 1'b0);
        expect_beat("t1_b0", 8'hAA, 1'b0);
        expect_beat("t1_b1", 8'hBB, 1'b0);
        idle(3);

        // Back-to-back words; the final byte carries last.
        send_word(1, 32'h2211, 1'b0);
        send_word(1, 32'h4433, 1'b1);
        expect_beat("t2_b2", 8'h33, 1'b0);
        expect_beat("t2_b3", 8'h44, 1'b1);
        idle(3);

        // Three stalled cycles on the first beat.
        down_ready_v[1] = 1'b0;
        send_word(1, 32'hDDCC, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_beat("t3_hold", 8'hCC, 1'b0);
            check("t3_up_ready", 32'(up_ready_v[1]), 32'd0);
        end
        @(posedge clk); #1;
        down_ready_v[1] = 1'b1;
        expect_beat("t3_b0", 8'hCC, 1'b0);
        expect_beat("t3_b1", 8'hDD, 1'b0);
        idle(3);

        // Reset lands while the upper byte is still pending.
        send_word(1, 32'hFFEE, 1'b0);
        expect_beat("t4_b0", 8'hEE, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_rst_valid", 32'(down_valid_v[1]), 32'd0);
        check("t4_rst_last", 32'(down_last_v[1]), 32'd0);
        check("t4_rst_up_ready", 32'(up_ready_v[1]), 32'd1);
        idle(1);
        send_word(1, 32'h0201, 1'b0);
        expect_beat("t4_b0n", 8'h01, 1'b0);
        expect_beat("t4_b1n", 8'h02, 1'b0);
        idle(3);

        // Random traffic on all three widths; up_valid holds until accepted.
        fired = 3'b111;
        for (int c = 0; c < 800; c++) begin
            for (int g = 0; g < 3; g++) begin
                if (!up_valid_v[g] || fired[g]) begin
                    up_valid_v[g] = ($urandom_range(0, 9) < 6);
                    up_data_v[g]  = $urandom;
                    up_last_v[g]  = $urandom_range(0, 1) == 1;
                end
                down_ready_v[g] = ($urandom_range(0, 9) < 7);
            end
            @(negedge clk);
            fired = up_valid_v & up_ready_v;
            @(posedge clk); #1;
        end
        up_valid_v   = '0;
        down_ready_v = 3'b111;
        idle(12);
        @(negedge clk);
        for (int g = 0; g < 3; g++)
            check("drain_valid", 32'(down_valid_v[g]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
